noise_arbiter: RTL and testbench



---
 rtl/noise_pkg.sv | 18 +
 rtl/lfsr_step.sv | 68 ++++++
 rtl/noise_arbiter.sv | 150 +++++++++++++++
 tb/tb_noise_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared types and constants for the noise arbiter: FSM states, default seed, LFSR taps.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [30:0] DEFAULT_SEED = 31'h608420dd;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 2;

  function automatic logic [30:0] lfsr_next(input logic [30:0] sr);
    return {sr[29:0], sr[TAP_LO] ^ sr[TAP_HI]};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// 31-bit noise LFSR with step enable and load; the next-state value is exported so callers can
// sample post-step bits in the same cycle. NOISE_ARB_LOCKUP_GUARD_EN adds zero-state recovery and a sticky lockup flag.
module lfsr_step
  import noise_pkg::*;
#(
  parameter logic [30:0] SEED   = DEFAULT_SEED,
  parameter int          WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [30:0]       i_load_val,
  output logic [WORD_W-1:0] o_next_word,
  output logic              o_next_msb
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
  ,
  output logic              o_lockup
`endif
);

  logic [30:0] r_sr;
  logic [30:0] w_next;

`ifdef NOISE_ARB_LOCKUP_GUARD_EN
  // A zero SEED would reload zero forever, so fall back to the package default in that case.
  localparam logic [30:0] RELOAD = (SEED != 31'd0) ? SEED : DEFAULT_SEED;
  logic r_lockup;
`endif

  always_comb begin
    w_next = r_sr;
    if (i_load) begin
      w_next = i_load_val;
    end else if (i_step) begin
      w_next = lfsr_next(r_sr);
    end
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    if (r_sr == 31'd0) begin
      w_next = RELOAD;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= SEED;
    end else begin
      r_sr <= w_next;
    end
  end

`ifdef NOISE_ARB_LOCKUP_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lockup <= 1'b0;
    end else if (r_sr == 31'd0) begin
      r_lockup <= 1'b1;
    end
  end

  assign o_lockup = r_lockup;
`endif

  assign o_next_word = w_next[WORD_W-1:0];
  assign o_next_msb  = w_next[30];

endmodule

// File: rtl/noise_arbiter.sv
// Shares one LFSR between a TICK_HZ audio noise bit and round-robin word requesters (grant WORD_W+1 cycles after req is seen).
// Requesters hold req until granted; optional NOISE_ARB_LOCKUP_GUARD_EN adds the lockup output.
module noise_arbiter
  import noise_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter int          WORD_W  = 8,
  parameter logic [30:0] SEED    = DEFAULT_SEED,
  parameter int          CLK_HZ  = 100_000_000,
  parameter int          TICK_HZ = 80_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WORD_W-1:0]  data,
  output logic               v,
  output logic               tick
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
  ,
  output logic               lockup
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int BW  = $clog2(WORD_W + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [CW-1:0]      r_cnt;
  state_t             r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_win;
  logic [BW-1:0]      r_bcnt;
  logic [NUM_REQ-1:0] r_mask;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WORD_W-1:0]  r_data;
  logic               r_v;

  logic               w_tick;
  logic               w_step;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic [IW:0]        w_sum;
  logic [WORD_W-1:0]  w_next_word;
  logic               w_next_msb;

  assign w_tick = (r_cnt == CW'(DIV - 1));
  assign w_step = w_tick || (r_state == BURST);
  assign w_elig = req & ~r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Scan offsets high to low so the nearest eligible requester at or after ptr is the last to win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      if (w_elig[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  lfsr_step #(
    .SEED   (SEED),
    .WORD_W (WORD_W)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .i_step      (w_step),
    .i_load      (1'b0),
    .i_load_val  (31'd0),
    .o_next_word (w_next_word),
    .o_next_msb  (w_next_msb)
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    ,
    .o_lockup    (lockup)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 1'b0;
    end else if (w_tick) begin
      r_v <= w_next_msb;
    end
  end

  // gnt and data are registered on the last burst edge so they are both visible during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_bcnt  <= '0;
      r_mask  <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
    end else begin
      r_gnt  <= '0;
      r_mask <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_win   <= w_pick;
            r_bcnt  <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          r_bcnt <= r_bcnt + 1'b1;
          if (r_bcnt == BW'(WORD_W - 1)) begin
            r_gnt   <= ONE << r_win;
            r_data  <= w_next_word;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
          r_mask  <= ONE << r_win;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign data = r_data;
  assign v    = r_v;
  assign tick = w_tick;

endmodule

// File: tb/tb_noise_arbiter.sv
// Self-checking bench for noise_arbiter: vector table, corner sequences and a cycle model from the rules.
module tb_noise_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int DIV = 1250;
  localparam logic [30:0] SEED_C = 31'h608420dd;

  typedef struct packed {
    logic [N-1:0] rq;
    logic [N-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] data;
  logic         v;
  logic         tick;

  logic         rst_z;
  logic [N-1:0] req_z;
  logic [N-1:0] gnt_z;
  logic [W-1:0] data_z;
  logic         v_z;
  logic         tick_z;
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
  logic         lockup;
  logic         lockup_z;
`endif

  int checks = 0;
  int errors = 0;

  noise_arbiter #(
    .NUM_REQ (N),
    .WORD_W  (W),
    .SEED    (SEED_C),
    .CLK_HZ  (100_000_000),
    .TICK_HZ (80_000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .data (data),
    .v    (v),
    .tick (tick)
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    ,
    .lockup (lockup)
`endif
  );

  noise_arbiter #(
    .NUM_REQ (N),
    .WORD_W  (W),
    .SEED    (31'h0),
    .CLK_HZ  (100),
    .TICK_HZ (10)
  ) dut_z (
    .clk  (clk),
    .rst  (rst_z),
    .req  (req_z),
    .gnt  (gnt_z),
    .data (data_z),
    .v    (v_z),
    .tick (tick_z)
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    ,
    .lockup (lockup_z)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: LFSR value, tick counter, and a request's progress as a cycle index.
  logic [30:0]  m_sr;
  int           m_cnt;
  int           m_phase;
  int           m_win;
  int           m_ptr;
  bit           m_mask_v;
  int           m_mask_idx;
  logic         m_v;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_data;

  task automatic model_reset();
    m_sr = SEED_C; m_cnt = 0; m_phase = 0; m_win = 0; m_ptr = 0;
    m_mask_v = 0; m_mask_idx = 0; m_v = 1'b0; m_gnt = '0; m_data = '0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] elig;
    bit tk;
    int p;
    tk = (m_cnt == DIV - 1);
    if (tk || (m_phase >= 1 && m_phase <= W)) m_sr = {m_sr[29:0], m_sr[30] ^ m_sr[2]};
    if (tk) m_v = m_sr[30];
    m_cnt = (m_cnt + 1) % DIV;
    m_gnt = '0;
    if (m_phase == 0) begin
      elig = r;
      if (m_mask_v) elig[m_mask_idx] = 1'b0;
      m_mask_v = 0;
      p = rr_pick(elig, m_ptr);
      if (p >= 0) begin
        m_win = p;
        m_phase = 1;
      end
    end else if (m_phase <= W) begin
      if (m_phase == W) begin
        m_gnt[m_win] = 1'b1;
        m_data = m_sr[W-1:0];
      end
      m_phase++;
    end else begin
      m_phase = 0;
      m_ptr = (m_win + 1) % N;
      m_mask_v = 1;
      m_mask_idx = m_win;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(req);
      #1;
      chk("tick", tick, (m_cnt == DIV - 1));
      chk("gnt", gnt, m_gnt);
      chk("data", data, m_data);
      chk("v", v, m_v);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  vec_t tbl[7];
  int   exp_order[5] = '{0, 1, 2, 3, 0};
  int   got[5];
  int   stamp[5];

  initial begin
    int n, gi, pend, idx, tick_at, nt;
    logic [N-1:0] seen;
    logic seen_v;

    rst = 1'b0; rst_z = 1'b1; req = '0; req_z = '0;
    tbl[0] = '{4'b0100, 4'b0100};
    tbl[1] = '{4'b0011, 4'b0001};
    tbl[2] = '{4'b1001, 4'b1000};
    tbl[3] = '{4'b0110, 4'b0010};
    tbl[4] = '{4'b1111, 4'b0100};
    tbl[5] = '{4'b1001, 4'b1000};
    tbl[6] = '{4'b0011, 4'b0001};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0); chk("rst_data", data, 0);
    chk("rst_v", v, 0);     chk("rst_tick", tick, 0);
    rst = 1'b0;

    // Round-robin vectors: each request set from the current pointer, latency fixed at WORD_W+1.
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].rq;
      n = 0;
      while (gnt == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rr_gnt", gnt, tbl[i].exp);
      chk("rr_latency", n, W + 1);
      req = '0;
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a burst and mid-count: no grant may follow.
    req = 4'b0001;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_rst_gnt", gnt, 0); chk("abort_rst_v", v, 0); chk("abort_rst_tick", tick, 0);
    req = '0;
    rst = 1'b0;
    seen = '0;
    repeat (15) begin
      @(negedge clk);
      seen |= gnt;
    end
    chk("abort_no_gnt", seen, 0);

    // All four requesting; each drops on grant and reasserts one cycle later.
    req = 4'b1111; gi = 0; n = 0; pend = -1;
    while (gi < 5 && n < 100) begin
      @(negedge clk);
      n++;
      if (pend >= 0) begin
        req[pend] = 1'b1;
        pend = -1;
      end
      if (gnt != '0) begin
        idx = 0;
        for (int k = 0; k < N; k++) if (gnt[k]) idx = k;
        got[gi] = idx;
        stamp[gi] = n;
        gi++;
        req[idx] = 1'b0;
        pend = idx;
      end
    end
    req = '0;
    chk("order_count", gi, 5);
    for (int i = 0; i < gi; i++) begin
      chk("order", got[i], exp_order[i]);
      if (i > 0) chk("spacing", stamp[i] - stamp[i-1], W + 2);
    end

    // Place a tick on the third burst cycle.
    repeat (3) @(negedge clk);
    n = 0;
    while (m_cnt != DIV - 4 && n < 2 * DIV) begin
      @(negedge clk);
      n++;
    end
    req = 4'b0010; n = 0; tick_at = -1;
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
      if (tick && tick_at < 0) tick_at = n;
    end
    req = '0;
    chk("tb_gnt", gnt, 4'b0010);
    chk("tb_latency", n, W + 1);
    chk("tb_tick_pos", tick_at, 3);

    // Idle: tick period.
    n = 0;
    while (!tick && n < DIV + 10) begin
      @(negedge clk);
      n++;
    end
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      n = 1;
      while (!tick && n < DIV + 10) begin
        @(negedge clk);
        n++;
      end
      chk("tick_period", n, DIV);
    end

    // Random request traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
    end
    req = '0;

    // Zero-seed instance.
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    chk("lockup_z_rst", lockup_z, 0);
`endif
    @(negedge clk);
    rst_z = 1'b0;
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    @(posedge clk);
    #1;
    chk("lockup_z_set", lockup_z, 1);
`endif
    nt = 0; seen_v = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tick_z) nt++;
      seen_v |= v_z;
    end
    chk("z_ticks", nt, 6);
`ifdef NOISE_ARB_LOCKUP_GUARD_EN
    chk("z_v_toggles", seen_v, 1);
    chk("lockup_main", lockup, 0);
`else
    chk("z_v_stuck", seen_v, 0);
`endif
    chk("z_gnt", gnt_z, 0);
    chk("z_data", data_z, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
